psum_requant: RTL
=================

# psum_requant

Output stage directly downstream of the partial-sum accumulator in the CNN datapath. It accepts each finished signed accumulated sum, adds a per-item bias and applies a round-half-up arithmetic right shift. It then applies optional ReLU and saturates to the activation width. Results are buffered in a small FIFO and streamed to the next layer's input buffer over a valid/ready handshake.

## Interface
Parameters:
- IN_BITS, 16, width of accumulated input and bias (signed)
- OUT_BITS, 8, width of output activation (signed)
- SHIFT_BITS, 4, width of shift amount (unsigned)
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input item present
- in_ready  out  1  block can accept an item this cycle
- in_data  in  IN_BITS  signed accumulated sum
- bias  in  IN_BITS  signed bias, sampled with the item
- shift  in  SHIFT_BITS  right-shift amount, sampled with the item
- relu_en  in  1  clamp negatives to 0, sampled with the item
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer accepts the result this cycle
- out_data  out  OUT_BITS  signed requantized activation
- sat_pulse  out  1  one-cycle pulse when the item written to the FIFO this cycle was saturated
- sat_count  out  16  saturation event count (see Configuration)

## Operation
- Input accept occurs when in_valid & in_ready. At that edge, stage-1 registers capture the following values:
  - in_data, bias, shift and relu_en
  - sum = sign-extended in_data + bias, held at IN_BITS+1 bits, so the add never wraps
- Stage 2 is combinational from the stage-1 registers and writes into the FIFO at the next edge.
  - shift = 0: r = sum.
  - shift > 0: r = (sum + 2^(shift-1)) >>> shift, computed at IN_BITS+2 bits. This is round-half-up toward +inf.
  - relu_en = 1 and r < 0: r = 0.
  - Saturation clamps r to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1]. sat_pulse is asserted when clamping occurred. A ReLU clamp alone is not saturation.
- FIFO behaviour:
  - Standard synchronous FIFO, in order, never overwrites.
  - Pop occurs on out_valid & out_ready.
  - out_valid = FIFO not empty.
  - out_data = head entry and is held stable while out_valid & !out_ready.
- Flow control is credit based:
  - in_ready = (fifo_count + s1_valid) < FIFO_DEPTH.
  - A pop in the same cycle is not credited, which keeps in_ready a registered-state function and free of any combinational path from out_ready.
- Simultaneous push and pop: count unchanged, both take effect.
- in_valid with in_ready = 0: nothing captured. The upstream holds its data.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - out_valid = 0, out_data = 0, sat_pulse = 0, sat_count = 0
  - s1_valid = 0, FIFO empty
  - in_ready = 1 in the first cycle after release
- Latency: an item accepted in cycle N appears with out_valid in cycle N+2 when the FIFO is empty.
- Throughput: 1 item/cycle while out_ready is held high.
- Reset mid-operation discards all in-flight and buffered items immediately. No partial output follows release.
- sat_pulse aligns with the FIFO write edge, i.e. cycle N+1 for an item accepted in cycle N.

## Configuration
- PSUM_SAT_CNT_EN defined: sat_count increments on each sat_pulse and saturates at 16'hFFFF. It does not wrap.
- PSUM_SAT_CNT_EN undefined: no counter logic is built and sat_count is tied to 0. sat_pulse is present in both builds.

## Structure
- Shared package psum_pkg holds the following:
  - default widths (IN_BITS, OUT_BITS, SHIFT_BITS, FIFO_DEPTH)
  - OUT_MAX / OUT_MIN constants derived from OUT_BITS
  - a typedef for the stage-1 payload struct (sum, shift, relu_en)
- One sub-module, psum_fifo: parameterised width/depth synchronous FIFO with count output and the same async active-low reset.
- Stage-1 register and the requant/saturate logic live in the top.

## Test plan
- Reset → out_valid = 0, out_data = 0, sat_count = 0, in_ready = 1 one cycle after release.
- in_data = 100, bias = 28, shift = 0, relu_en = 0 → out_data = 127, sat_pulse = 1, out_valid two cycles after accept.
- in_data = -300, bias = 0, shift = 2: relu_en = 0 → out_data = -75; relu_en = 1 → out_data = 0 with sat_pulse = 0. Also in_data = 6, shift = 2 → out_data = 2 (round half up).
- in_data = 16'h7FFF, bias = 16'h7FFF, shift = 0 → no internal wrap, out_data = 127. With the macro defined, sat_count increments by 1.
- out_ready = 0 and 6 back-to-back inputs → in_ready deasserts after 4 accepts and nothing is lost. Then out_ready = 1 → all 6 results emerge in order with no duplicates.
- reset asserted while FIFO holds 3 items → out_valid falls asynchronously. After release no stale item appears.

Source files
------------

// File: rtl/psum_pkg.sv
// psum_pkg: shared widths, activation limits and the stage-1 payload type
// for the partial-sum requantization stage.
package psum_pkg;

  localparam int DEF_IN_BITS    = 16;
  localparam int DEF_OUT_BITS   = 8;
  localparam int DEF_SHIFT_BITS = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int OUT_MAX = (1 << (DEF_OUT_BITS - 1)) - 1;
  localparam int OUT_MIN = -(1 << (DEF_OUT_BITS - 1));

  // Stage-1 payload: the widened sum plus the per-item requant controls.
  typedef struct packed {
    logic signed [DEF_IN_BITS:0]   sum;
    logic [DEF_SHIFT_BITS-1:0]     shift;
    logic                          relu_en;
  } s1_payload_t;

endpackage

// File: rtl/psum_fifo.sv
// psum_fifo: in-order synchronous FIFO with occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored, and the
// read port shows zero while empty so the head is never stale data.
module psum_fifo
  import psum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointers and occupancy; depth is a power of two so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents need no reset because reads are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/psum_requant.sv
// psum_requant: bias add, round-half-up right shift, optional ReLU and
// saturation of accumulated partial sums, buffered in an output FIFO.
// Optional feature: define PSUM_SAT_CNT_EN to build the saturation counter;
// otherwise sat_count is tied to zero.
module psum_requant
  import psum_pkg::*;
#(
  parameter int IN_BITS    = DEF_IN_BITS,
  parameter int OUT_BITS   = DEF_OUT_BITS,
  parameter int SHIFT_BITS = DEF_SHIFT_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_BITS-1:0]   in_data,
  input  logic signed [IN_BITS-1:0]   bias,
  input  logic [SHIFT_BITS-1:0]       shift,
  input  logic                        relu_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_BITS-1:0]  out_data,
  output logic                        sat_pulse,
  output logic [15:0]                 sat_count
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int W_BITS = IN_BITS + 2;
  localparam logic signed [W_BITS-1:0] SAT_HI = W_BITS'((1 << (OUT_BITS - 1)) - 1);
  localparam logic signed [W_BITS-1:0] SAT_LO = W_BITS'(-(1 << (OUT_BITS - 1)));

  logic                      accept;
  logic                      s1_valid;
  s1_payload_t               s1_q;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_empty;
  logic signed [W_BITS-1:0]  sum_w;
  logic signed [W_BITS-1:0]  half;
  logic signed [W_BITS-1:0]  res;
  logic [OUT_BITS-1:0]       res_q;
  logic                      res_sat;

  // Credit counts the FIFO plus the stage-1 slot; a same-cycle pop is not
  // credited so in_ready depends only on registered state.
  assign accept    = in_valid & in_ready;
  assign in_ready  = (fifo_count + CNT_W'(s1_valid)) < CNT_W'(FIFO_DEPTH);
  assign out_valid = ~fifo_empty;
  assign sat_pulse = s1_valid & res_sat;

  // Stage 1: capture the item and form the one-bit-wider sum so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_q.sum     <= (IN_BITS+1)'(in_data) + (IN_BITS+1)'(bias);
        s1_q.shift   <= shift;
        s1_q.relu_en <= relu_en;
      end
    end
  end

  // Stage 2: round-half-up shift, then ReLU, then clamp to the activation range.
  always_comb begin
    sum_w   = W_BITS'(s1_q.sum);
    half    = '0;
    res     = sum_w;
    res_sat = 1'b0;
    if (s1_q.shift != '0) begin
      half = W_BITS'(1) << (s1_q.shift - SHIFT_BITS'(1));
      res  = (sum_w + half) >>> s1_q.shift;
    end
    if (s1_q.relu_en && res[W_BITS-1]) begin
      res = '0;
    end
    if (res > SAT_HI) begin
      res     = SAT_HI;
      res_sat = 1'b1;
    end else if (res < SAT_LO) begin
      res     = SAT_LO;
      res_sat = 1'b1;
    end
    res_q = res[OUT_BITS-1:0];
  end

  psum_fifo #(
    .WIDTH (OUT_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (s1_valid),
    .wr_data (res_q),
    .pop     (out_valid & out_ready),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef PSUM_SAT_CNT_EN
  // Saturation event counter that sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_count <= '0;
    end else if (sat_pulse && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`else
  assign sat_count = '0;
`endif

endmodule
